// File: rtl/steer_quad_gen.sv
// Turns left/right steering requests into a Gray-code quadrature stream that mimics
// a rotating wheel encoder, with a slow step rate that speeds up once a direction is held.
module steer_quad_gen #(
    parameter int DIV_W       = 16,
    parameter int ACCEL_STEPS = 8,
    parameter int FAST_SHIFT  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             right,
    input  logic             left,
    output logic [1:0]       steer,
    output logic             moving
);

    localparam int SC_W = (ACCEL_STEPS < 1) ? 1 : $clog2(ACCEL_STEPS + 1);
    localparam logic [SC_W-1:0] STEP_MAX = SC_W'(ACCEL_STEPS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_SLOW = 2'd1,
        RUN_FAST = 2'd2
    } state_t;

    // A single held step already reaches the fast rate when ACCEL_STEPS is 1.
    localparam state_t PRESS_STATE = (ACCEL_STEPS <= 1) ? RUN_FAST : RUN_SLOW;

    state_t           state_reg;
    logic [1:0]       req_meta_reg;
    logic [1:0]       req_sync_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [SC_W-1:0]  stepcnt_reg;
    logic             run_dir_reg;

    logic             dir_valid;
    logic             dir_up;
    logic [DIV_W-1:0] fast_raw;
    logic [DIV_W-1:0] slow_period;
    logic [DIV_W-1:0] fast_period;
    logic [DIV_W-1:0] last_cnt;
    logic [SC_W-1:0]  stepcnt_next;

    function automatic logic [1:0] gray_step(input logic [1:0] g, input logic up);
        logic [1:0] r;
        case (g)
            2'b00:   r = up ? 2'b01 : 2'b10;
            2'b01:   r = up ? 2'b11 : 2'b00;
            2'b11:   r = up ? 2'b10 : 2'b01;
            default: r = up ? 2'b00 : 2'b11;
        endcase
        return r;
    endfunction

    // Bit 1 of the synchroniser carries right, bit 0 carries left.
    assign dir_valid = req_sync_reg[1] ^ req_sync_reg[0];
    assign dir_up    = req_sync_reg[1];

    assign fast_raw    = clkdiv >> FAST_SHIFT;
    assign slow_period = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
    assign fast_period = (fast_raw == '0) ? DIV_W'(1) : fast_raw;
    assign last_cnt    = ((state_reg == RUN_FAST) ? fast_period : slow_period) - DIV_W'(1);

    assign stepcnt_next = (stepcnt_reg >= STEP_MAX) ? STEP_MAX : stepcnt_reg + SC_W'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_meta_reg <= 2'b00;
            req_sync_reg <= 2'b00;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            stepcnt_reg  <= '0;
            run_dir_reg  <= 1'b0;
            steer        <= 2'b00;
            moving       <= 1'b0;
        end else begin
            req_meta_reg <= {right, left};
            req_sync_reg <= req_meta_reg;

            if (state_reg == IDLE) begin
                cnt_reg <= '0;
                if (dir_valid) begin
                    steer       <= gray_step(steer, dir_up);
                    run_dir_reg <= dir_up;
                    stepcnt_reg <= SC_W'(1);
                    state_reg   <= PRESS_STATE;
                    moving      <= 1'b1;
                end
            end else begin
                if (!dir_valid) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    stepcnt_reg <= '0;
                    moving      <= 1'b0;
                end else if (dir_up != run_dir_reg) begin
                    // Reversal restarts acceleration from scratch in the new direction.
                    steer       <= gray_step(steer, dir_up);
                    run_dir_reg <= dir_up;
                    stepcnt_reg <= SC_W'(1);
                    cnt_reg     <= '0;
                    state_reg   <= PRESS_STATE;
                end else if (cnt_reg >= last_cnt) begin
                    // >= lets a shortened period take effect without wrapping cnt.
                    steer       <= gray_step(steer, run_dir_reg);
                    cnt_reg     <= '0;
                    stepcnt_reg <= stepcnt_next;
                    if (stepcnt_next == STEP_MAX) begin
                        state_reg <= RUN_FAST;
                    end
                end else begin
                    cnt_reg <= cnt_reg + DIV_W'(1);
                end
            end
        end
    end

endmodule
